// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-side PC/pipeline-register sequencer (boot, redirect arbitration, debug halt)
// Optional performance counters are built only when PERF_CNT_EN is defined.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          BOOT_WAIT    = 2,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        CLk,
    input  logic        REset,
    input  logic        StallReq,
    input  logic        BrTaken,
    input  logic [63:0] BrTarget,
    input  logic        JmpReq,
    input  logic [63:0] JmpTarget,
    input  logic        HaltReq,
    input  logic        ResumeReq,
    output logic        PCWRite,
    output logic        JUmp,
    output logic [63:0] NEwPC,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        Halted,
    output logic [31:0] StallCount,
    output logic [31:0] RedirectCount
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam logic [15:0] BOOT_LOAD  = 16'(BOOT_WAIT);
    localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        stall_hit;

    // The shared counter expires on the edge where it steps from 1 to 0.
    always_ff @(posedge CLk) begin
        if (!REset) begin
            state_q <= ST_BOOT;
            cnt_q   <= BOOT_LOAD;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (cnt_q <= 16'd1) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (HaltReq) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q != 16'd0) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (cnt_q <= 16'd1) begin
                        state_q <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (ResumeReq && !HaltReq) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    cnt_q   <= BOOT_LOAD;
                end
            endcase
        end
    end

    // Mealy decode: reset forces the boot values even before the first edge.
    always_comb begin
        PCWRite   = 1'b0;
        JUmp      = 1'b0;
        NEwPC     = 64'h0;
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        Halted    = 1'b0;
        stall_hit = 1'b0;
        if (!REset || state_q == ST_BOOT) begin
            JUmp      = 1'b1;
            NEwPC     = RESET_VECTOR;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    stall_hit = StallReq && !BrTaken;
                    if (BrTaken) begin
                        JUmp      = 1'b1;
                        NEwPC     = BrTarget;
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (JmpReq) begin
                        JUmp      = 1'b1;
                        NEwPC     = JmpTarget;
                        IFIDFlush = 1'b1;
                    end else if (StallReq) begin
                        IDEXFlush = 1'b1;
                    end else begin
                        PCWRite   = 1'b1;
                        IFIDWrite = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    IFIDFlush = 1'b1;
                    stall_hit = StallReq && !BrTaken;
                    if (BrTaken) begin
                        JUmp      = 1'b1;
                        NEwPC     = BrTarget;
                        IDEXFlush = 1'b1;
                    end else if (JmpReq) begin
                        JUmp  = 1'b1;
                        NEwPC = JmpTarget;
                    end
                    if (stall_hit) begin
                        IDEXFlush = 1'b1;
                    end
                end
                ST_HALTED: begin
                    Halted    = 1'b1;
                    IFIDFlush = 1'b1;
                end
                default: begin
                    JUmp      = 1'b1;
                    NEwPC     = RESET_VECTOR;
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge CLk) begin
        if (!REset) begin
            stall_cnt_q    <= 32'h0;
            redirect_cnt_q <= 32'h0;
        end else begin
            if (stall_hit && stall_cnt_q != 32'hFFFF_FFFF) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (JUmp && state_q != ST_BOOT && redirect_cnt_q != 32'hFFFF_FFFF) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign StallCount    = REset ? stall_cnt_q : 32'h0;
    assign RedirectCount = REset ? redirect_cnt_q : 32'h0;
`else
    logic unused_stall_hit;
    assign unused_stall_hit = stall_hit;
    assign StallCount       = 32'h0;
    assign RedirectCount    = 32'h0;
`endif

endmodule
